// File: rtl/conv_mac_sequencer_pkg.sv
// Shared state type and address-width helpers for the convolution MAC sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam int DEF_INW  = 16;
  localparam int DEF_OUTW = 64;
  localparam int DEF_R    = 8;
  localparam int DEF_K    = 3;

  // A one-entry memory still needs a one-bit address port.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int x_addr_w(input int r);
    return addr_w(r * r);
  endfunction

  function automatic int w_addr_w(input int k);
    return addr_w(k * k);
  endfunction

  function automatic int y_addr_w(input int r, input int k);
    return addr_w((r - k + 1) * (r - k + 1));
  endfunction

  function automatic int num_outputs(input int r, input int k);
    return (r - k + 1) * (r - k + 1);
  endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Bundle of control, memory, MAC and result-stream signals around the sequencer.
interface conv_mac_sequencer_if import conv_pkg::*; #(
  parameter int INW  = DEF_INW,
  parameter int OUTW = DEF_OUTW,
  parameter int R    = DEF_R,
  parameter int K    = DEF_K
);

  logic                           start;
  logic signed [INW-1:0]          bias;
  logic                           busy;
  logic                           done;
  logic [x_addr_w(R)-1:0]         x_addr;
  logic signed [INW-1:0]          x_rdata;
  logic [w_addr_w(K)-1:0]         w_addr;
  logic signed [INW-1:0]          w_rdata;
  logic signed [INW-1:0]          mac_input0;
  logic signed [INW-1:0]          mac_input1;
  logic signed [INW-1:0]          mac_init_value;
  logic                           mac_init_acc;
  logic                           mac_input_valid;
  logic signed [OUTW-1:0]         mac_out;
  logic signed [OUTW-1:0]         y_data;
  logic [y_addr_w(R, K)-1:0]      y_addr;
  logic                           y_valid;
  logic                           y_ready;

  modport master (
    input  start, bias, x_rdata, w_rdata, mac_out, y_ready,
    output busy, done, x_addr, w_addr, mac_input0, mac_input1,
           mac_init_value, mac_init_acc, mac_input_valid,
           y_data, y_addr, y_valid
  );

  modport slave (
    output start, bias, x_rdata, w_rdata, mac_out, y_ready,
    input  busy, done, x_addr, w_addr, mac_input0, mac_input1,
           mac_init_value, mac_init_acc, mac_input_valid,
           y_data, y_addr, y_valid
  );

endinterface

// File: rtl/conv_mac_sequencer_addr_gen.sv
// Output-position and kernel-tap counters with the derived image, weight and result addresses.
module conv_addr_gen import conv_pkg::*; #(
  parameter int R = DEF_R,
  parameter int K = DEF_K
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      tap_step,
  input  logic                      out_step,
  output logic [x_addr_w(R)-1:0]    x_addr,
  output logic [w_addr_w(K)-1:0]    w_addr,
  output logic [y_addr_w(R, K)-1:0] y_addr,
  output logic                      first_tap,
  output logic                      last_tap,
  output logic                      last_output
);

  localparam int CW = x_addr_w(R);
  localparam int WW = w_addr_w(K);
  localparam int YW = y_addr_w(R, K);
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] O_LAST = CW'(R - K);
  localparam logic [YW-1:0] Y_LAST = YW'(num_outputs(R, K) - 1);

  // Every counter fits in the image address width since all are below R*R.
  logic [CW-1:0] orow, ocol, kr, kc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orow <= '0;
      ocol <= '0;
      kr   <= '0;
      kc   <= '0;
    end else if (clear) begin
      orow <= '0;
      ocol <= '0;
      kr   <= '0;
      kc   <= '0;
    end else begin
      if (tap_step) begin
        if (kc == K_LAST) begin
          kc <= '0;
          kr <= (kr == K_LAST) ? '0 : kr + CW'(1);
        end else begin
          kc <= kc + CW'(1);
        end
      end
      if (out_step) begin
        if (ocol == O_LAST) begin
          ocol <= '0;
          orow <= (orow == O_LAST) ? '0 : orow + CW'(1);
        end else begin
          ocol <= ocol + CW'(1);
        end
      end
    end
  end

  assign x_addr      = (orow + kr) * CW'(R) + ocol + kc;
  assign w_addr      = WW'(kr * CW'(K) + kc);
  assign y_addr      = YW'(orow * CW'(R - K + 1) + ocol);
  assign first_tap   = (kr == '0) && (kc == '0);
  assign last_tap    = (kr == K_LAST) && (kc == K_LAST);
  assign last_output = (y_addr == Y_LAST);

endmodule

// File: rtl/conv_mac_sequencer.sv
// FSM, MAC-issue delay and result register driving a pipelined MAC across a full convolution.
// Define CONV_RELU_EN to clamp negative accumulations to zero when the result is captured.
module conv_mac_sequencer import conv_pkg::*; #(
  parameter int R = DEF_R,
  parameter int K = DEF_K
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_mac_sequencer_if.master  bus
);

  localparam int XW = x_addr_w(R);
  localparam int WW = w_addr_w(K);
  localparam int YW = y_addr_w(R, K);

  state_t         state, next_state;
  logic [1:0]     drain_cnt;
  logic           issue, accept, out_hs, drain_end;
  logic           first_tap, last_tap, last_output;
  logic [XW-1:0]  x_addr;
  logic [WW-1:0]  w_addr;
  logic [YW-1:0]  y_addr;

  conv_addr_gen #(.R(R), .K(K)) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept),
    .tap_step    (issue),
    .out_step    (out_hs),
    .x_addr      (x_addr),
    .w_addr      (w_addr),
    .y_addr      (y_addr),
    .first_tap   (first_tap),
    .last_tap    (last_tap),
    .last_output (last_output)
  );

  assign bus.x_addr     = x_addr;
  assign bus.w_addr     = w_addr;
  assign bus.y_addr     = y_addr;
  assign bus.mac_input0 = bus.x_rdata;
  assign bus.mac_input1 = bus.w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_LOAD;
      S_LOAD:  if (last_tap) next_state = S_DRAIN;
      S_DRAIN: if (drain_end) next_state = S_OUT;
      S_OUT:   if (out_hs) next_state = last_output ? S_DONE : S_LOAD;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The third DRAIN cycle is the last one; the MAC holds the full sum by then.
  always_comb begin
    issue     = 1'b0;
    accept    = 1'b0;
    out_hs    = 1'b0;
    drain_end = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      S_IDLE:  accept = bus.start;
      S_LOAD:  begin issue = 1'b1; bus.busy = 1'b1; end
      S_DRAIN: begin drain_end = (drain_cnt == 2'd2); bus.busy = 1'b1; end
      S_OUT:   begin out_hs = bus.y_valid && bus.y_ready; bus.busy = 1'b1; end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Issue is delayed one cycle to line up with the synchronous memory read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt           <= 2'd0;
      bus.mac_input_valid <= 1'b0;
      bus.mac_init_acc    <= 1'b0;
      bus.mac_init_value  <= '0;
      bus.y_data          <= '0;
      bus.y_valid         <= 1'b0;
    end else begin
      drain_cnt           <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      bus.mac_input_valid <= issue;
      bus.mac_init_acc    <= issue && first_tap;
      if (accept) bus.mac_init_value <= bus.bias;
      if (drain_end) begin
`ifdef CONV_RELU_EN
        bus.y_data <= bus.mac_out[$bits(bus.mac_out)-1] ? '0 : bus.mac_out;
`else
        bus.y_data <= bus.mac_out;
`endif
        bus.y_valid <= 1'b1;
      end else if (out_hs) begin
        bus.y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Randomised scoreboard bench for conv_mac_sequencer with memory and two-stage MAC models (R=4, K=2).
module tb_conv_mac_sequencer;

  localparam int R    = 4;
  localparam int K    = 2;
  localparam int KK   = K * K;
  localparam int OD   = R - K + 1;
  localparam int NOUT = OD * OD;

  logic clk;
  logic reset;

  conv_mac_sequencer_if #(.INW(16), .OUTW(64), .R(R), .K(K)) bus ();

  conv_mac_sequencer #(.R(R), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int     addr;
    longint data;
  } exp_t;

  exp_t               sb_q[$];
  logic signed [15:0] x_mem [R*R];
  logic signed [15:0] w_mem [KK];
  longint             prod, acc;
  logic               v1, i1;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int hs_total    = 0;
  int done_cnt    = 0;
  int last_hs_cyc = -10;
  int last_rise   = 0;
  int exp_first   = 0;
  bit first_pending = 0;
  bit check_period  = 0;
  bit prev_valid    = 0;
  bit prev_hs       = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    bus.x_rdata <= x_mem[bus.x_addr];
    bus.w_rdata <= w_mem[bus.w_addr];
  end

  // Two-stage MAC: registered product, then accumulate (or restart from the init value).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= 0;
      acc  <= 0;
      v1   <= 1'b0;
      i1   <= 1'b0;
    end else begin
      v1   <= bus.mac_input_valid;
      i1   <= bus.mac_init_acc;
      prod <= longint'(bus.mac_input0) * longint'(bus.mac_input1);
      if (v1) acc <= i1 ? longint'(bus.mac_init_value) + prod : acc + prod;
    end
  end

  assign bus.mac_out = acc;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_out(input int p, input longint b);
    longint s;
    int orow;
    int ocol;
    s    = b;
    orow = p / OD;
    ocol = p % OD;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        s += longint'(x_mem[(orow + r) * R + ocol + c]) * longint'(w_mem[r * K + c]);
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < R * R; i++) begin
      case (mode)
        1:       x_mem[i] = 16'(i);
        3:       x_mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
        default: x_mem[i] = 16'sd1;
      endcase
    end
    for (int i = 0; i < KK; i++) begin
      case (mode)
        1:       w_mem[i] = (i == 0) ? 16'sd1 : ((i == KK - 1) ? -16'sd1 : 16'sd0);
        2:       w_mem[i] = -16'sd1;
        3:       w_mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
        default: w_mem[i] = 16'sd1;
      endcase
    end
  endtask

  // Monitor: every presented result is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (bus.y_valid && !prev_valid) begin
          if (first_pending) begin
            check_output("first_valid_cycle", cyc, exp_first);
            first_pending = 1'b0;
          end else if (check_period) begin
            check_output("output_period", cyc - last_rise, KK + 4);
          end
          last_rise = cyc;
        end
        if (bus.y_valid) begin
          check_output("no_fetch_while_out", bus.mac_input_valid, 0);
          if (sb_q.size() == 0) begin
            check_output("unexpected_output", bus.y_addr, -1);
          end else begin
            check_output("y_addr", bus.y_addr, sb_q[0].addr);
            check_output("y_data", bus.y_data, sb_q[0].data);
            if (bus.y_ready) begin
              void'(sb_q.pop_front());
              hs_total++;
              last_hs_cyc = cyc;
            end
          end
        end else if (prev_valid && !prev_hs) begin
          check_output("y_valid_held", bus.y_valid, 1);
        end
        if (bus.done) begin
          check_output("done_after_last_hs", cyc, last_hs_cyc + 1);
          done_cnt++;
        end
        prev_valid = bus.y_valid;
        prev_hs    = bus.y_valid && bus.y_ready;
      end
    end
  end

  // ready_mode: 0 always ready, 1 random ready, 2 six-cycle stall on output 3.
  task automatic apply_stimulus(input logic signed [15:0] b, input int ready_mode,
                                input bit timing, input int abort_at, input bit dbl);
    int base_hs, base_done, stall, it, abort_wait;
    bit finished;
    for (int p = 0; p < NOUT; p++) sb_q.push_back('{p, ref_out(p, longint'(b))});
    base_hs    = hs_total;
    base_done  = done_cnt;
    stall      = 6;
    it         = 0;
    abort_wait = 0;
    finished   = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.bias      = b;
    bus.y_ready   = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    exp_first     = cyc + KK + 4;
    first_pending = timing;
    check_period  = timing;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!finished && it < 2000) begin
      case (ready_mode)
        1: bus.y_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.y_valid && bus.y_addr == 3 && stall > 0) begin
            bus.y_ready = 1'b0;
            stall--;
          end else begin
            bus.y_ready = 1'b1;
          end
        end
        default: bus.y_ready = 1'b1;
      endcase
      if (dbl && it == 5) begin
        bus.start = 1'b1;
        bus.bias  = b + 16'sd7;
      end else begin
        bus.start = 1'b0;
      end
      if (abort_at >= 0 && hs_total - base_hs >= abort_at) begin
        abort_wait++;
        if (abort_wait == 2) begin
          #2 reset = 1'b1;
          #1;
          check_output("abort_y_valid", bus.y_valid, 0);
          check_output("abort_busy", bus.busy, 0);
          check_output("abort_mac_valid", bus.mac_input_valid, 0);
          check_output("abort_init_acc", bus.mac_init_acc, 0);
          check_output("abort_y_data", bus.y_data, 0);
          check_output("abort_x_addr", bus.x_addr, 0);
          sb_q.delete();
          first_pending = 1'b0;
          @(posedge clk); #1;
          reset = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          check_output("abort_no_done", done_cnt - base_done, 0);
          check_output("abort_idle", bus.busy, 0);
          return;
        end
      end
      @(posedge clk); #1;
      it++;
      if (done_cnt != base_done) finished = 1'b1;
    end
    bus.start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: got %0d outputs expected %0d", hs_total - base_hs, NOUT);
    end
    check_output("done_once", done_cnt - base_done, 1);
    check_output("outputs_seen", hs_total - base_hs, NOUT);
    check_output("scoreboard_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic signed [15:0] rb;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.bias    = '0;
    bus.y_ready = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_y_valid", bus.y_valid, 0);
    check_output("rst_y_data", bus.y_data, 0);
    check_output("rst_y_addr", bus.y_addr, 0);
    check_output("rst_x_addr", bus.x_addr, 0);
    check_output("rst_w_addr", bus.w_addr, 0);
    check_output("rst_mac_valid", bus.mac_input_valid, 0);
    check_output("rst_init_acc", bus.mac_init_acc, 0);
    check_output("rst_init_value", bus.mac_init_value, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("idle_busy", bus.busy, 0);

    $display("[TB] all-ones image and kernel");
    fill(0);
    apply_stimulus(16'sd0, 0, 1'b1, -1, 1'b0);

    $display("[TB] ramp image, difference kernel, bias 5");
    fill(1);
    apply_stimulus(16'sd5, 0, 1'b1, -1, 1'b0);

    $display("[TB] negative kernel");
    fill(2);
    apply_stimulus(16'sd0, 0, 1'b0, -1, 1'b0);

    $display("[TB] backpressure on output 3");
    fill(3);
    rb = 16'(int'($urandom_range(0, 2000)) - 1000);
    apply_stimulus(rb, 2, 1'b0, -1, 1'b0);

    $display("[TB] reset during output 2, then restart with a stray start");
    fill(0);
    apply_stimulus(16'sd0, 0, 1'b0, 2, 1'b0);
    apply_stimulus(16'sd3, 0, 1'b1, -1, 1'b1);

    $display("[TB] random data with random backpressure");
    for (int n = 0; n < 3; n++) begin
      fill(3);
      rb = 16'(int'($urandom_range(0, 2000)) - 1000);
      apply_stimulus(rb, 1, 1'b0, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
